q_div: RTL
==========

Q_DIV -- requirements
Module: q_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a division; sampled only in IDLE.
REQ-004 SHALL have port in, input, 8 bits: dividend, loaded into Q when start is accepted.
REQ-005 SHALL have port qbit, input, 1 bit: quotient bit from the A/M subtract stage (1 = partial remainder non-negative).
REQ-006 SHALL have port c5, input, 1 bit: bus output enable.
REQ-007 SHALL have port out, output, 8 bits: Q register contents.
REQ-008 SHALL have port outbus, output, 8 bits: out when c5=1, else 8'h00; combinational, no latch.
REQ-009 SHALL have port a_in, output, 1 bit: Q MSB shifted into A; equals out[7] combinationally.
REQ-010 SHALL have port c_shift, output, 1 bit: strobe telling A to shift left in the same cycle; high only in SHIFT.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse, high only in DONE.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, SET and DONE.
REQ-014 In IDLE with start=1, SHALL load out<=in, clear cnt (3-bit) and go to SHIFT; start=0 holds IDLE and out.
REQ-015 In SHIFT, SHALL assert c_shift, set out<={out[6:0],1'b0} and go to SET.
REQ-016 In SET, SHALL set out[0]<=qbit and cnt<=cnt+1; go to DONE if cnt==7, else to SHIFT.
REQ-017 In DONE, SHALL hold out, assert done for exactly one cycle and go to IDLE.
REQ-018 Latency SHALL be: start accepted at edge k gives 8 SHIFT/SET pairs (16 cycles), with done high in the 17th cycle after edge k; the quotient is in out from that cycle on.
REQ-019 Outside IDLE, start SHALL be ignored, with no restart and no reload.
REQ-020 cnt SHALL wrap 7->0 only through completion; exactly 8 qbit samples per division.
REQ-021 out SHALL be held in IDLE and DONE; in and qbit SHALL be ignored outside the IDLE load and SET respectively.
REQ-022 If start=1 in the cycle DONE is entered or is active, it SHALL take effect only after returning to IDLE, at the next edge.
REQ-023 c5 SHALL be independent of the FSM; outbus SHALL track out in every state.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, out=8'h00, cnt=0, busy=0, done=0 and c_shift=0; outbus=0 regardless of c5 (out=0).
REQ-025 Reset mid-division SHALL abort with no done pulse; the first start after rst falls SHALL begin a fresh division.

Structure
REQ-026 Package q_div_pkg SHALL hold Q_WIDTH=8, N_ITER=8, the state enum {IDLE,SHIFT,SET,DONE} and the counter width $clog2(N_ITER).
REQ-027 The FSM plus iteration counter SHALL be separable as sub-module q_div_ctrl (outputs load, shift, set, busy, done); the datapath stays in q_div.

Verification
REQ-028 Reset check: assert rst mid-cycle with c5=1 -> out=0, outbus=0, busy=0, done=0 asynchronously.
REQ-029 Load/shift-out check: in=8'h75, start, qbit=1 held -> a_in in successive SHIFT cycles = 0,1,1,1,0,1,0,1; final out=8'hFF.
REQ-030 Timing check: qbit=0 held -> out=8'h00; done high exactly one cycle, 17 cycles after the start edge; busy high 17 cycles; c_shift high 8 cycles.
REQ-031 Bit-order check: in=8'h3C, qbit alternating 1,0,... per SET -> out=8'hAA; repeat with start held high throughout -> the second division starts only after DONE->IDLE.
REQ-032 Abort check: rst pulsed during the 3rd SET -> IDLE, no done; then in=8'h01, start, qbit=1 -> out=8'hFF, done after 17 cycles.
REQ-033 Bus check: c5=0 -> outbus=8'h00 in all states; c5=1 -> outbus==out every cycle, including mid-division.

Source files
------------

// File: rtl/q_div_pkg.sv
// Shared widths, iteration count and controller state encoding for the
// restoring-division Q register slice.
package q_div_pkg;
  localparam int unsigned Q_WIDTH = 8;
  localparam int unsigned N_ITER  = 8;
  localparam int unsigned CNT_W   = $clog2(N_ITER);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SET   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/q_div_ctrl.sv
// Sequencer for the Q register: one SHIFT/SET pair per quotient bit,
// N_ITER pairs per division, then a single-cycle DONE.
module q_div_ctrl
  import q_div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic shift,
  output logic set,
  output logic busy,
  output logic done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             idle;

  // start is only honoured while idle; the datapath loads on the same edge
  assign load = idle & start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idle  <= 1'b1;
      shift <= 1'b0;
      set   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      shift <= 1'b0;
      set   <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            idle  <= 1'b0;
            shift <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          state <= SET;
          set   <= 1'b1;
        end
        SET: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N_ITER - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= SHIFT;
            shift <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          idle  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/q_div.sv
// Q (dividend/quotient) register of a shift-subtract divider: MSB feeds the
// A register, quotient bits enter at the LSB from the subtract stage.
module q_div
  import q_div_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [Q_WIDTH-1:0] in,
  input  logic               qbit,
  input  logic               c5,
  output logic [Q_WIDTH-1:0] out,
  output logic [Q_WIDTH-1:0] outbus,
  output logic               a_in,
  output logic               c_shift,
  output logic               busy,
  output logic               done
);

  logic load;
  logic shift;
  logic set;

  q_div_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .load  (load),
    .shift (shift),
    .set   (set),
    .busy  (busy),
    .done  (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end else if (shift) begin
      out <= {out[Q_WIDTH-2:0], 1'b0};
    end else if (set) begin
      out[0] <= qbit;
    end
  end

  assign c_shift = shift;
  assign a_in    = out[Q_WIDTH-1];
  assign outbus  = c5 ? out : '0;

endmodule
